// File: rtl/xgmii_rx_monitor_if.sv
// xgmii_rx_monitor_if: the XGMII receive bus as the monitor sees it.
// Signals: xgmii_d (lane i = [8i+7:8i]) and xgmii_c (bit i qualifies lane i).
interface xgmii_rx_monitor_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH/8
);
  logic [DATA_WIDTH-1:0] xgmii_d;
  logic [CTRL_WIDTH-1:0] xgmii_c;

  modport master (
    output xgmii_d,
    output xgmii_c
  );

  modport slave (
    input xgmii_d,
    input xgmii_c
  );
endinterface

// File: rtl/xgmii_rx_monitor.sv
// xgmii_rx_monitor: passive XGMII rx monitor; frame length/status and counters.
// Ports: clk, rst (async high), xgmii (slave d/c), clear, in_frame,
// frame_done, frame_len, frame_bad, good_count, bad_count, sticky_err.
module xgmii_rx_monitor #(
  parameter int DATA_WIDTH  = 64,
  parameter int CTRL_WIDTH  = DATA_WIDTH/8,
  parameter int LEN_WIDTH   = 16,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  xgmii_rx_monitor_if.slave      xgmii,
  input  logic                   clear,
  output logic                   in_frame,
  output logic                   frame_done,
  output logic [LEN_WIDTH-1:0]   frame_len,
  output logic                   frame_bad,
  output logic [COUNT_WIDTH-1:0] good_count,
  output logic [COUNT_WIDTH-1:0] bad_count,
  output logic                   sticky_err
);

  localparam logic [7:0] CH_START = 8'hFB;
  localparam logic [7:0] CH_TERM  = 8'hFD;

  localparam logic [LEN_WIDTH-1:0]   LEN_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  // START may open a frame only on a column boundary.
  function automatic logic start_lane(int i);
    return (i == 0) || (DATA_WIDTH == 64 && i == 4);
  endfunction

  logic [CTRL_WIDTH-1:0] is_data;
  logic [CTRL_WIDTH-1:0] is_start;
  logic [CTRL_WIDTH-1:0] is_term;

  // ERROR, IDLE and other control all end up in the default arm
  // of the walk below, so only START and TERM need a decode.
  always_comb begin
    for (int i = 0; i < CTRL_WIDTH; i++) begin
      is_data[i]  = !xgmii.xgmii_c[i];
      is_start[i] = xgmii.xgmii_c[i]
                    && xgmii.xgmii_d[8*i +: 8] == CH_START
                    && start_lane(i);
      is_term[i]  = xgmii.xgmii_c[i]
                    && xgmii.xgmii_d[8*i +: 8] == CH_TERM;
    end
  end

  logic                 open_q;
  logic                 bad_q;
  logic [LEN_WIDTH-1:0] len_q;

  logic                 open_n;
  logic                 bad_n;
  logic [LEN_WIDTH-1:0] len_n;
  logic                 close_n;
  logic                 close_bad;
  logic [LEN_WIDTH-1:0] close_len;

  // Serial byte walk over the lanes. If two closes land in one
  // word the later one overwrites the earlier report.
  always_comb begin
    open_n    = open_q;
    bad_n     = bad_q;
    len_n     = len_q;
    close_n   = 1'b0;
    close_bad = 1'b0;
    close_len = '0;
    for (int i = 0; i < CTRL_WIDTH; i++) begin
      unique case (1'b1)
        is_data[i]: begin
          if (open_n && len_n != LEN_MAX)
            len_n = len_n + LEN_WIDTH'(1);
        end
        is_start[i]: begin
          if (open_n) begin
            close_n   = 1'b1;
            close_bad = 1'b1;
            close_len = len_n;
          end
          open_n = 1'b1;
          bad_n  = 1'b0;
          len_n  = '0;
        end
        is_term[i]: begin
          if (open_n) begin
            close_n   = 1'b1;
            close_bad = bad_n;
            close_len = len_n;
            open_n    = 1'b0;
          end
        end
        default: begin
          if (open_n)
            bad_n = 1'b1;
        end
      endcase
    end
  end

  assign in_frame = open_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      open_q     <= 1'b0;
      bad_q      <= 1'b0;
      len_q      <= '0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      frame_bad  <= 1'b0;
      good_count <= '0;
      bad_count  <= '0;
      sticky_err <= 1'b0;
    end else begin
      open_q     <= open_n;
      bad_q      <= bad_n;
      len_q      <= len_n;
      frame_done <= close_n;
      if (close_n) begin
        frame_len <= close_len;
        frame_bad <= close_bad;
      end
      // clear wins over a same-cycle increment
      if (clear) begin
        good_count <= '0;
        bad_count  <= '0;
        sticky_err <= 1'b0;
      end else if (close_n) begin
        if (close_bad) begin
          sticky_err <= 1'b1;
          if (bad_count != CNT_MAX)
            bad_count <= bad_count + COUNT_WIDTH'(1);
        end else if (good_count != CNT_MAX) begin
          good_count <= good_count + COUNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_xgmii_rx_monitor.sv
// tb_xgmii_rx_monitor: scoreboard bench over 64-, 8- and 32-bit builds.
// Byte-walk reference model, directed frames, random traffic, async reset.
module tb_xgmii_rx_monitor;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  always #5 clk = ~clk;

  xgmii_rx_monitor_if #(.DATA_WIDTH(64)) if0 ();
  xgmii_rx_monitor_if #(.DATA_WIDTH(8))  if1 ();
  xgmii_rx_monitor_if #(.DATA_WIDTH(32)) if2 ();

  logic        inf0, done0, fbad0, st0;
  logic [15:0] len0;
  logic [31:0] gc0, bc0;
  logic        inf1, done1, fbad1, st1;
  logic [15:0] len1;
  logic [1:0]  gc1, bc1;
  logic        inf2, done2, fbad2, st2;
  logic [3:0]  len2;
  logic [31:0] gc2, bc2;

  xgmii_rx_monitor #(.DATA_WIDTH(64)) u64 (
    .clk(clk), .rst(rst), .xgmii(if0.slave), .clear(clear),
    .in_frame(inf0), .frame_done(done0), .frame_len(len0),
    .frame_bad(fbad0), .good_count(gc0), .bad_count(bc0),
    .sticky_err(st0)
  );

  xgmii_rx_monitor #(.DATA_WIDTH(8), .COUNT_WIDTH(2)) u8 (
    .clk(clk), .rst(rst), .xgmii(if1.slave), .clear(clear),
    .in_frame(inf1), .frame_done(done1), .frame_len(len1),
    .frame_bad(fbad1), .good_count(gc1), .bad_count(bc1),
    .sticky_err(st1)
  );

  xgmii_rx_monitor #(.DATA_WIDTH(32), .LEN_WIDTH(4)) u32 (
    .clk(clk), .rst(rst), .xgmii(if2.slave), .clear(clear),
    .in_frame(inf2), .frame_done(done2), .frame_len(len2),
    .frame_bad(fbad2), .good_count(gc2), .bad_count(bc2),
    .sticky_err(st2)
  );

  typedef struct {
    bit     inf;
    bit     done;
    bit     bad;
    bit     st;
    longint len;
    longint gc;
    longint bc;
  } snap_t;

  snap_t sq[3][$];

  int     nl[3]   = '{8, 1, 4};
  longint lmax[3] = '{65535, 65535, 15};
  longint cmax[3] = '{64'hFFFF_FFFF, 3, 64'hFFFF_FFFF};

  bit     m_open[3];
  bit     m_bad[3];
  bit     m_st[3];
  longint m_len[3];
  longint m_gc[3];
  longint m_bc[3];

  logic [63:0] wd[3];
  logic [7:0]  wc[3];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic sample(int k, output snap_t s);
    case (k)
      0: begin
        s.inf = inf0; s.done = done0; s.bad = fbad0; s.st = st0;
        s.len = longint'(len0);
        s.gc = longint'(gc0); s.bc = longint'(bc0);
      end
      1: begin
        s.inf = inf1; s.done = done1; s.bad = fbad1; s.st = st1;
        s.len = longint'(len1);
        s.gc = longint'(gc1); s.bc = longint'(bc1);
      end
      default: begin
        s.inf = inf2; s.done = done2; s.bad = fbad2; s.st = st2;
        s.len = longint'(len2);
        s.gc = longint'(gc2); s.bc = longint'(bc2);
      end
    endcase
  endtask

  // Reference: flatten the word into a byte list and apply the
  // frame rules one byte at a time.
  task automatic model(int k, logic [63:0] d, logic [7:0] c, bit clr);
    snap_t       s;
    bit          cl;
    bit          cb;
    longint      cln;
    logic [7:0]  bytes[$];
    bit          ctls[$];
    cl  = 0;
    cb  = 0;
    cln = 0;
    for (int i = 0; i < nl[k]; i++) begin
      bytes.push_back(d[8*i +: 8]);
      ctls.push_back(c[i]);
    end
    foreach (bytes[i]) begin
      bit legal;
      legal = (i == 0) || (i == 4 && nl[k] == 8);
      if (!ctls[i]) begin
        if (m_open[k] && m_len[k] < lmax[k]) m_len[k]++;
      end else if (bytes[i] == 8'hFB && legal) begin
        if (m_open[k]) begin
          cl = 1; cb = 1; cln = m_len[k];
        end
        m_open[k] = 1; m_bad[k] = 0; m_len[k] = 0;
      end else if (bytes[i] == 8'hFD) begin
        if (m_open[k]) begin
          cl = 1; cb = m_bad[k]; cln = m_len[k];
          m_open[k] = 0;
        end
      end else if (m_open[k]) begin
        m_bad[k] = 1;
      end
    end
    if (cl) begin
      if (cb) begin
        m_st[k] = 1;
        if (m_bc[k] < cmax[k]) m_bc[k]++;
      end else if (m_gc[k] < cmax[k]) begin
        m_gc[k]++;
      end
    end
    if (clr) begin
      m_gc[k] = 0; m_bc[k] = 0; m_st[k] = 0;
    end
    s.inf  = m_open[k];
    s.done = cl;
    s.bad  = cb;
    s.len  = cln;
    s.gc   = m_gc[k];
    s.bc   = m_bc[k];
    s.st   = m_st[k];
    sq[k].push_back(s);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_open[k] = 0; m_bad[k] = 0; m_st[k] = 0;
      m_len[k] = 0; m_gc[k] = 0; m_bc[k] = 0;
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      wd[k] = 64'h0707_0707_0707_0707;
      wc[k] = 8'hFF;
    end
  endtask

  task automatic lane(int k, int i, bit c, logic [7:0] b);
    wd[k][8*i +: 8] = b;
    wc[k][i] = c;
  endtask

  task automatic data_lanes(int k, int lo, int hi);
    for (int i = lo; i <= hi; i++) lane(k, i, 1'b0, 8'($urandom));
  endtask

  task automatic rnd_word(int k);
    int r;
    for (int i = 0; i < nl[k]; i++) begin
      r = $urandom_range(0, 99);
      if (r < 72)      lane(k, i, 1'b0, 8'($urandom));
      else if (r < 80) lane(k, i, 1'b1, 8'hFB);
      else if (r < 88) lane(k, i, 1'b1, 8'hFD);
      else if (r < 94) lane(k, i, 1'b1, 8'h07);
      else if (r < 97) lane(k, i, 1'b1, 8'hFE);
      else             lane(k, i, 1'b1, 8'h9C);
    end
  endtask

  // Issue one word per build on the falling edge and queue the
  // expected post-edge state.
  task automatic tick(bit clr = 1'b0);
    @(negedge clk);
    if0.xgmii_d = wd[0];
    if0.xgmii_c = wc[0];
    if1.xgmii_d = wd[1][7:0];
    if1.xgmii_c = wc[1][0:0];
    if2.xgmii_d = wd[2][31:0];
    if2.xgmii_c = wc[2][3:0];
    clear = clr;
    for (int k = 0; k < 3; k++) model(k, wd[k], wc[k], clr);
    idle_all();
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: one expected snapshot per sampled word.
  initial begin
    snap_t e;
    snap_t a;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (sq[k].size() > 0) begin
          e = sq[k].pop_front();
          sample(k, a);
          chk($sformatf("u%0d in_frame", k), a.inf, e.inf);
          chk($sformatf("u%0d frame_done", k), a.done, e.done);
          if (e.done && a.done) begin
            chk($sformatf("u%0d frame_len", k), a.len, e.len);
            chk($sformatf("u%0d frame_bad", k), a.bad, e.bad);
          end
          chk($sformatf("u%0d good_count", k), a.gc, e.gc);
          chk($sformatf("u%0d bad_count", k), a.bc, e.bc);
          chk($sformatf("u%0d sticky_err", k), a.st, e.st);
        end
      end
    end
  end

  task automatic chk_zero(string tag);
    snap_t a;
    for (int k = 0; k < 3; k++) begin
      sample(k, a);
      chk($sformatf("%s u%0d in_frame", tag, k), a.inf, 0);
      chk($sformatf("%s u%0d frame_done", tag, k), a.done, 0);
      chk($sformatf("%s u%0d frame_len", tag, k), a.len, 0);
      chk($sformatf("%s u%0d frame_bad", tag, k), a.bad, 0);
      chk($sformatf("%s u%0d good_count", tag, k), a.gc, 0);
      chk($sformatf("%s u%0d bad_count", tag, k), a.bc, 0);
      chk($sformatf("%s u%0d sticky_err", tag, k), a.st, 0);
    end
  endtask

  initial begin
    rst   = 1'b0;
    clear = 1'b0;
    idle_all();
    if0.xgmii_d = wd[0];
    if0.xgmii_c = wc[0];
    if1.xgmii_d = wd[1][7:0];
    if1.xgmii_c = wc[1][0:0];
    if2.xgmii_d = wd[2][31:0];
    if2.xgmii_c = wc[2][3:0];
    model_reset();
    #1 rst = 1'b1;
    #2 chk_zero("reset");
    #5 rst = 1'b0;

    // 64-bit: 60 data bytes, good frame
    lane(0, 0, 1'b1, 8'hFB);
    data_lanes(0, 1, 7);
    tick();
    repeat (6) begin
      data_lanes(0, 0, 7);
      tick();
    end
    data_lanes(0, 0, 4);
    lane(0, 5, 1'b1, 8'hFD);
    tick();
    after_edge();
    chk("tp1 frame_done", done0, 1);
    chk("tp1 frame_len", len0, 60);
    chk("tp1 frame_bad", fbad0, 0);
    chk("tp1 good_count", gc0, 1);

    // 64-bit: ERROR in the third word, then clear
    lane(0, 0, 1'b1, 8'hFB);
    data_lanes(0, 1, 7);
    tick();
    data_lanes(0, 0, 7);
    tick();
    data_lanes(0, 0, 7);
    lane(0, 3, 1'b1, 8'hFE);
    tick();
    lane(0, 0, 1'b1, 8'hFD);
    tick();
    after_edge();
    chk("tp2 frame_bad", fbad0, 1);
    chk("tp2 bad_count", bc0, 1);
    chk("tp2 sticky_err", st0, 1);
    tick(1'b1);
    after_edge();
    chk("tp2 clr bad_count", bc0, 0);
    chk("tp2 clr good_count", gc0, 0);
    chk("tp2 clr sticky_err", st0, 0);

    // 64-bit: TERM then START(lane 4) in one word
    lane(0, 0, 1'b1, 8'hFB);
    data_lanes(0, 1, 7);
    tick();
    lane(0, 0, 1'b1, 8'hFD);
    lane(0, 4, 1'b1, 8'hFB);
    data_lanes(0, 5, 7);
    tick();
    after_edge();
    chk("tp3 frame_done", done0, 1);
    chk("tp3 frame_len", len0, 7);
    chk("tp3 in_frame", inf0, 1);
    data_lanes(0, 0, 1);
    lane(0, 2, 1'b1, 8'hFD);
    tick();
    after_edge();
    chk("tp3 next frame_len", len0, 5);

    // 8-bit: 64 data bytes; 32-bit: START in lane 2 is ignored
    lane(1, 0, 1'b1, 8'hFB);
    lane(2, 2, 1'b1, 8'hFB);
    tick();
    after_edge();
    chk("tp4 lane2 start in_frame", inf2, 0);
    repeat (64) begin
      data_lanes(1, 0, 0);
      tick();
    end
    lane(1, 0, 1'b1, 8'hFD);
    tick();
    after_edge();
    chk("tp4 8b frame_len", len1, 64);

    // 8-bit, 2-bit counters: four more good frames saturate at 3
    repeat (4) begin
      lane(1, 0, 1'b1, 8'hFB);
      tick();
      data_lanes(1, 0, 0);
      tick();
      lane(1, 0, 1'b1, 8'hFD);
      tick();
    end
    after_edge();
    chk("tp5 good_count sat", gc1, 3);

    // 32-bit, 4-bit length: 20 data bytes saturate at 15
    lane(2, 0, 1'b1, 8'hFB);
    data_lanes(2, 1, 3);
    tick();
    repeat (4) begin
      data_lanes(2, 0, 3);
      tick();
    end
    data_lanes(2, 0, 0);
    lane(2, 1, 1'b1, 8'hFD);
    tick();
    after_edge();
    chk("tp5 frame_len sat", len2, 15);
    chk("tp5 frame_bad", fbad2, 0);

    // random traffic on all three builds
    for (int n = 0; n < 3000; n++) begin
      bit clr;
      for (int k = 0; k < 3; k++) rnd_word(k);
      if ($urandom_range(0, 9) == 0) idle_all();
      clr = ($urandom_range(0, 199) == 0);
      tick(clr);
    end
    tick();
    tick();

    // async reset mid-frame
    lane(0, 0, 1'b1, 8'hFB);
    data_lanes(0, 1, 7);
    tick();
    after_edge();
    chk("pre-reset in_frame", inf0, 1);
    data_lanes(0, 0, 7);
    tick();
    #2 rst = 1'b1;
    for (int k = 0; k < 3; k++) void'(sq[k].pop_back());
    model_reset();
    #1 chk_zero("async rst");
    @(posedge clk);
    #2 rst = 1'b0;
    data_lanes(0, 0, 7);
    tick();
    data_lanes(0, 0, 2);
    lane(0, 3, 1'b1, 8'hFD);
    tick();
    after_edge();
    chk("post-rst frame_done", done0, 0);
    chk("post-rst in_frame", inf0, 0);
    tick();
    after_edge();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
